// File: rtl/esram_arbiter.sv
// N-channel request arbiter and transfer sequencer in front of the eSRAM AHB master.
// One transfer in flight at a time; completion is signalled by a one-cycle ack (and err on timeout).
module esram_arbiter #(
   parameter int          NUM_CH    = 2,
   parameter int          ADDR_W    = 16,
   parameter int          DATA_W    = 8,
   parameter logic [31:0] BASE_ADDR = 32'h2000_0000,
   parameter int          RR_MODE   = 1,
   parameter int          TIMEOUT   = 255
) (
   input  logic                       clk,
   input  logic                       rst,
   input  logic [NUM_CH-1:0]          req,
   input  logic [NUM_CH-1:0]          wr,
   input  logic [NUM_CH*ADDR_W-1:0]   addr,
   input  logic [NUM_CH*DATA_W-1:0]   wdata,
   output logic [NUM_CH-1:0]          ack,
   output logic [NUM_CH-1:0]          err,
   output logic [DATA_W-1:0]          rdata,
   output logic                       busy,
   output logic [31:0]                ahb_addr,
   output logic [DATA_W-1:0]          ahb_data_out,
   output logic                       ahb_write,
   output logic                       ahb_read,
   input  logic [DATA_W-1:0]          ahb_data_in,
   input  logic                       ahb_valid,
   input  logic                       ahb_busy
);

   localparam int CH_W = (NUM_CH > 1) ? $clog2(NUM_CH) : 1;

   typedef enum logic [1:0] {IDLE, START, RUN, DONE} state_t;

   state_t            state;
   logic [CH_W-1:0]   rr_ptr;
   logic [CH_W-1:0]   gnt;
   logic [CH_W-1:0]   win;
   logic [CH_W-1:0]   next_ptr;
   logic [NUM_CH-1:0] gnt_oh;
   logic              is_write;
   logic [7:0]        tmo_cnt;
   logic              tmo_hit;
   int                idx;

   // NOTE: every always_comb output gets a default first so no latch is inferred.
   always_comb begin
      win = '0;
      idx = 0;
      if (RR_MODE != 0) begin
         // Scan from the farthest slot back to the pointer so the nearest requester is taken last.
         for (int k = NUM_CH - 1; k >= 0; k--) begin
            idx = (int'(rr_ptr) + k) % NUM_CH;
            if (req[CH_W'(idx)]) win = CH_W'(idx);
         end
      end else begin
         for (int i = 0; i < NUM_CH; i++)
            if (req[CH_W'(i)]) win = CH_W'(i);
      end
   end

   always_comb begin
      gnt_oh      = '0;
      gnt_oh[gnt] = 1'b1;
   end

   assign next_ptr = (gnt == CH_W'(NUM_CH - 1)) ? '0 : gnt + CH_W'(1);
   assign tmo_hit  = (tmo_cnt == 8'(TIMEOUT - 1));

   // NOTE: sequential state uses non-blocking assignments only; pulses default low each cycle.
   always_ff @(posedge clk) begin
      if (rst) begin
         state        <= IDLE;
         rr_ptr       <= '0;
         gnt          <= '0;
         is_write     <= 1'b0;
         tmo_cnt      <= '0;
         ack          <= '0;
         err          <= '0;
         rdata        <= '0;
         busy         <= 1'b0;
         ahb_addr     <= '0;
         ahb_data_out <= '0;
         ahb_write    <= 1'b0;
         ahb_read     <= 1'b0;
      end else begin
         ahb_write <= 1'b0;
         ahb_read  <= 1'b0;
         ack       <= '0;
         err       <= '0;
         case (state)
            IDLE: begin
               if (|req) begin
                  gnt          <= win;
                  is_write     <= wr[win];
                  ahb_addr     <= BASE_ADDR + 32'(addr[win*ADDR_W +: ADDR_W]);
                  ahb_data_out <= wdata[win*DATA_W +: DATA_W];
                  ahb_write    <= wr[win];
                  ahb_read     <= ~wr[win];
                  tmo_cnt      <= '0;
                  busy         <= 1'b1;
                  state        <= START;
               end
            end
            START, RUN: begin
               tmo_cnt <= tmo_cnt + 8'd1;
               // A real completion on the same edge as the timeout wins over the abort.
               if (!is_write && ahb_valid) begin
                  rdata <= ahb_data_in;
                  ack   <= gnt_oh;
                  state <= DONE;
               end else if (is_write && state == RUN && !ahb_busy) begin
                  ack   <= gnt_oh;
                  state <= DONE;
               end else if (tmo_hit) begin
                  if (!is_write) rdata <= '1;
                  ack   <= gnt_oh;
                  err   <= gnt_oh;
                  state <= DONE;
               end else if (state == START && ahb_busy) begin
                  state <= RUN;
               end
            end
            DONE: begin
               if (RR_MODE != 0) rr_ptr <= next_ptr;
               busy  <= 1'b0;
               state <= IDLE;
            end
            default: state <= IDLE;
         endcase
      end
   end

endmodule

// File: tb/tb_esram_arbiter.sv
// Directed bench for esram_arbiter: a round-robin instance and a fixed-priority instance
// share the master-side stimulus; only the instance being exercised has requests raised.
module tb_esram_arbiter;

   logic        clk = 1'b0;
   logic        rst = 1'b1;
   logic [3:0]  req = '0;
   logic [3:0]  req_f = '0;
   logic [3:0]  wr = '0;
   logic [63:0] addr = '0;
   logic [31:0] wdata = '0;
   logic [7:0]  ahb_data_in = '0;
   logic        ahb_valid = 1'b0;
   logic        ahb_busy = 1'b0;

   logic [3:0]  ack, err, ack_f, err_f;
   logic [7:0]  rdata, rdata_f, ahb_data_out, ahb_data_out_f;
   logic        busy, busy_f, ahb_write, ahb_write_f, ahb_read, ahb_read_f;
   logic [31:0] ahb_addr, ahb_addr_f;

   int tests_run = 0;
   int tests_failed = 0;

   always #5 clk = ~clk;

   esram_arbiter #(.NUM_CH(4), .ADDR_W(16), .DATA_W(8), .BASE_ADDR(32'h2000_0000),
                   .RR_MODE(1), .TIMEOUT(10)) dut (
      .clk(clk), .rst(rst), .req(req), .wr(wr), .addr(addr), .wdata(wdata),
      .ack(ack), .err(err), .rdata(rdata), .busy(busy), .ahb_addr(ahb_addr),
      .ahb_data_out(ahb_data_out), .ahb_write(ahb_write), .ahb_read(ahb_read),
      .ahb_data_in(ahb_data_in), .ahb_valid(ahb_valid), .ahb_busy(ahb_busy));

   esram_arbiter #(.NUM_CH(4), .ADDR_W(16), .DATA_W(8), .BASE_ADDR(32'h2000_0000),
                   .RR_MODE(0), .TIMEOUT(10)) dut_fp (
      .clk(clk), .rst(rst), .req(req_f), .wr(wr), .addr(addr), .wdata(wdata),
      .ack(ack_f), .err(err_f), .rdata(rdata_f), .busy(busy_f), .ahb_addr(ahb_addr_f),
      .ahb_data_out(ahb_data_out_f), .ahb_write(ahb_write_f), .ahb_read(ahb_read_f),
      .ahb_data_in(ahb_data_in), .ahb_valid(ahb_valid), .ahb_busy(ahb_busy));

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   // One write with an immediate master: grant, busy for one cycle, ack, back to IDLE.
   task automatic run_write(input bit fp, input int exp_ch, input string name);
      logic [31:0] exp_addr;
      logic [3:0]  exp_oh;
      exp_addr = 32'h2000_0000 + {16'h0, addr[exp_ch*16 +: 16]};
      exp_oh   = 4'b0001 << exp_ch;
      tick();
      tests_run++;
      if ((fp ? ahb_write_f : ahb_write) !== 1'b1) begin
         tests_failed++;
         $display("FAIL %s_strobe: ahb_write=%b expected 1", name, fp ? ahb_write_f : ahb_write);
      end
      tests_run++;
      if ((fp ? ahb_addr_f : ahb_addr) !== exp_addr) begin
         tests_failed++;
         $display("FAIL %s_addr: ahb_addr=%h expected %h", name, fp ? ahb_addr_f : ahb_addr, exp_addr);
      end
      ahb_busy = 1'b1;
      tick();
      ahb_busy = 1'b0;
      tick();
      tests_run++;
      if ((fp ? ack_f : ack) !== exp_oh) begin
         tests_failed++;
         $display("FAIL %s_ack: ack=%b expected %b", name, fp ? ack_f : ack, exp_oh);
      end
      tests_run++;
      if ((fp ? err_f : err) !== 4'b0000) begin
         tests_failed++;
         $display("FAIL %s_err: err=%b expected 0000", name, fp ? err_f : err);
      end
      tick();
   endtask

   task automatic test_reset();
      rst = 1'b1;
      tick();
      tick();
      tests_run++;
      if ({ack, err, rdata, busy, ahb_addr, ahb_data_out, ahb_write, ahb_read} !== 60'h0) begin
         tests_failed++;
         $display("FAIL reset_outputs: ack=%b err=%b rdata=%h busy=%b addr=%h dout=%h wr=%b rd=%b expected all 0",
                  ack, err, rdata, busy, ahb_addr, ahb_data_out, ahb_write, ahb_read);
      end
      rst = 1'b0;
      tick();
      tests_run++;
      if (busy !== 1'b0) begin
         tests_failed++;
         $display("FAIL reset_idle: busy=%b expected 0", busy);
      end
   endtask

   task automatic test_round_robin();
      int exp_seq[5] = '{0, 1, 2, 3, 0};
      for (int i = 0; i < 4; i++) addr[i*16 +: 16] = 16'h0100 * 16'(i + 1);
      wr  = 4'b1111;
      req = 4'b1111;
      for (int n = 0; n < 5; n++) run_write(1'b0, exp_seq[n], $sformatf("rr%0d", n));
      req = 4'b0000;
      tick();
   endtask

   task automatic test_write();
      req[0] = 1'b1;
      wr[0]  = 1'b1;
      addr[15:0]  = 16'h0010;
      wdata[7:0]  = 8'hA5;
      tick();
      tests_run++;
      if (ahb_write !== 1'b1 || ahb_read !== 1'b0 || ahb_addr !== 32'h2000_0010 || ahb_data_out !== 8'hA5) begin
         tests_failed++;
         $display("FAIL write_issue: wr=%b rd=%b addr=%h dout=%h expected 1 0 20000010 a5",
                  ahb_write, ahb_read, ahb_addr, ahb_data_out);
      end
      addr[15:0] = 16'h1234;
      wdata[7:0] = 8'h00;
      ahb_busy = 1'b1;
      for (int c = 0; c < 3; c++) begin
         tick();
         tests_run++;
         if (ahb_write !== 1'b0 || ack !== 4'b0000) begin
            tests_failed++;
            $display("FAIL write_busy%0d: ahb_write=%b ack=%b expected 0 0000", c, ahb_write, ack);
         end
      end
      tests_run++;
      if (ahb_addr !== 32'h2000_0010 || ahb_data_out !== 8'hA5) begin
         tests_failed++;
         $display("FAIL write_hold: addr=%h dout=%h expected 20000010 a5", ahb_addr, ahb_data_out);
      end
      ahb_busy = 1'b0;
      tick();
      tests_run++;
      if (ack !== 4'b0001 || err !== 4'b0000) begin
         tests_failed++;
         $display("FAIL write_ack: ack=%b err=%b expected 0001 0000", ack, err);
      end
      req[0] = 1'b0;
      tick();
      tests_run++;
      if (ack !== 4'b0000 || busy !== 1'b0) begin
         tests_failed++;
         $display("FAIL write_done: ack=%b busy=%b expected 0000 0", ack, busy);
      end
   endtask

   task automatic test_read();
      req[1] = 1'b1;
      wr[1]  = 1'b0;
      addr[31:16] = 16'hFFFF;
      tick();
      tests_run++;
      if (ahb_read !== 1'b1 || ahb_write !== 1'b0 || ahb_addr !== 32'h2000_FFFF) begin
         tests_failed++;
         $display("FAIL read_issue: rd=%b wr=%b addr=%h expected 1 0 2000ffff", ahb_read, ahb_write, ahb_addr);
      end
      ahb_data_in = 8'h3C;
      ahb_valid   = 1'b1;
      ahb_busy    = 1'b1;
      tick();
      tests_run++;
      if (ack !== 4'b0010 || rdata !== 8'h3C || err !== 4'b0000 || ahb_read !== 1'b0) begin
         tests_failed++;
         $display("FAIL read_return: ack=%b rdata=%h err=%b rd=%b expected 0010 3c 0000 0",
                  ack, rdata, err, ahb_read);
      end
      ahb_valid = 1'b0;
      ahb_busy  = 1'b0;
      req[1]    = 1'b0;
      tick();
   endtask

   task automatic test_timeout();
      req[3] = 1'b1;
      wr[3]  = 1'b0;
      tick();
      for (int c = 1; c <= 10; c++) begin
         tick();
         if (c < 10) begin
            tests_run++;
            if (ack !== 4'b0000) begin
               tests_failed++;
               $display("FAIL timeout_early%0d: ack=%b expected 0000", c, ack);
            end
         end
      end
      tests_run++;
      if (ack !== 4'b1000 || err !== 4'b1000 || rdata !== 8'hFF) begin
         tests_failed++;
         $display("FAIL timeout_abort: ack=%b err=%b rdata=%h expected 1000 1000 ff", ack, err, rdata);
      end
      req[3] = 1'b0;
      tick();
      req[2] = 1'b1;
      wr[2]  = 1'b1;
      run_write(1'b0, 2, "after_timeout");
      req[2] = 1'b0;
      tick();
   endtask

   task automatic test_fixed_priority();
      wr    = 4'b1111;
      req_f = 4'b1111;
      for (int n = 0; n < 3; n++) run_write(1'b1, 3, $sformatf("fp%0d", n));
      req_f = 4'b0111;
      run_write(1'b1, 2, "fp_drop3");
      req_f = 4'b0000;
      tick();
   endtask

   task automatic test_reset_mid_op();
      wr  = 4'b1111;
      req = 4'b0001;
      tick();
      ahb_busy = 1'b1;
      tick();
      rst = 1'b1;
      req = 4'b0000;
      tick();
      tests_run++;
      if ({ack, err, rdata, busy, ahb_addr, ahb_data_out, ahb_write, ahb_read} !== 60'h0) begin
         tests_failed++;
         $display("FAIL midop_reset: ack=%b err=%b rdata=%h busy=%b addr=%h dout=%h wr=%b rd=%b expected all 0",
                  ack, err, rdata, busy, ahb_addr, ahb_data_out, ahb_write, ahb_read);
      end
      rst      = 1'b0;
      ahb_busy = 1'b0;
      tick();
      tests_run++;
      if (ack !== 4'b0000 || busy !== 1'b0) begin
         tests_failed++;
         $display("FAIL midop_no_ack: ack=%b busy=%b expected 0000 0", ack, busy);
      end
      req = 4'b1100;
      run_write(1'b0, 2, "post_reset");
      req = 4'b0000;
      tick();
   endtask

   initial begin
      test_reset();
      test_round_robin();
      test_write();
      test_read();
      test_timeout();
      test_fixed_priority();
      test_reset_mid_op();
      $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
      $finish;
   end

   initial begin
      #200000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1);
   end

endmodule
